// File: rtl/microwave_control.sv
// Magnetron control FSM: conditions the front-panel buttons and door switch,
// then sequences IDLE/COOK/PAUSE/DONE and enables the magnetron and the cook timer.
module microwave_control #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic       timer_done,
  output logic       mag_on,
  output logic       timer_en,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COOK  = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t cur_state, nxt_state;

  logic [SYNC_STAGES-1:0] start_sync, stop_sync, door_sync;
  logic start_prev, stop_prev;
  logic start_press, stop_press, door_ok, go;

  // Synchronizers plus one history flop per button for falling-edge detection.
  // NOTE: every flop here is reset, to its inactive level, so no false press
  // or false door-closed is seen on the first cycles after reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      start_sync <= '1;
      stop_sync  <= '1;
      door_sync  <= '0;
      start_prev <= 1'b1;
      stop_prev  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value
      // of its neighbour, which is what turns this into a shift chain.
      start_sync <= {start_sync[SYNC_STAGES-2:0], startn};
      stop_sync  <= {stop_sync[SYNC_STAGES-2:0], stopn};
      door_sync  <= {door_sync[SYNC_STAGES-2:0], door_closed};
      start_prev <= start_sync[SYNC_STAGES-1];
      stop_prev  <= stop_sync[SYNC_STAGES-1];
    end
  end

  assign start_press = start_prev & ~start_sync[SYNC_STAGES-1];
  assign stop_press  = stop_prev & ~stop_sync[SYNC_STAGES-1];
  assign door_ok     = door_sync[SYNC_STAGES-1];
  // A simultaneous stop press always cancels a start press.
  assign go          = start_press & door_ok & ~timer_done & ~stop_press;

  always_comb begin
    // NOTE: default assignment first, so no path through the case infers a latch.
    nxt_state = cur_state;
    unique case (cur_state)
      IDLE: begin
        if (go) nxt_state = COOK;
      end
      COOK: begin
        if (!door_ok)        nxt_state = PAUSE;
        else if (timer_done) nxt_state = DONE;
        else if (stop_press) nxt_state = PAUSE;
      end
      PAUSE: begin
        if (stop_press) nxt_state = IDLE;
        else if (go)    nxt_state = COOK;
      end
      DONE: begin
        if (stop_press || !door_ok) nxt_state = IDLE;
        else if (go)                nxt_state = COOK;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Outputs are flops loaded from the next state, so they never glitch and
  // always match the state register exactly.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cur_state <= IDLE;
      mag_on    <= 1'b0;
      timer_en  <= 1'b0;
      done      <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      mag_on    <= (nxt_state == COOK);
      timer_en  <= (nxt_state == COOK);
      done      <= (nxt_state == DONE);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_microwave_control.sv
// Self-checking bench for microwave_control: directed test-plan steps followed
// by random button/door/timer activity, all compared against a delay-line model.
module tb_microwave_control;

  localparam int S = 2;
  localparam int M_IDLE = 0, M_COOK = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       clrn, startn, stopn, door_closed, timer_done;
  logic       mag_on, timer_en, done;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  microwave_control #(.SYNC_STAGES(S)) dut (
    .clk(clk), .clrn(clrn), .startn(startn), .stopn(stopn),
    .door_closed(door_closed), .timer_done(timer_done),
    .mag_on(mag_on), .timer_en(timer_en), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: each asynchronous input is seen S-1 edges late (h[S-1]),
  // a press is a 1->0 step between consecutive delayed samples.
  logic st_h [S+1];
  logic sp_h [S+1];
  logic dr_h [S+1];
  int   m_state;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i <= S; i++) begin
        st_h[i] = 1'b1;
        sp_h[i] = 1'b1;
        dr_h[i] = 1'b0;
      end
      m_state = M_IDLE;
    end else begin
      logic st, sp, ok, can_start;
      st = st_h[S] && !st_h[S-1];
      sp = sp_h[S] && !sp_h[S-1];
      ok = dr_h[S-1];
      can_start = st && !sp && ok && !timer_done;
      case (m_state)
        M_IDLE:  if (can_start) m_state = M_COOK;
        M_COOK:  if (!ok || (sp && !timer_done)) m_state = M_PAUSE;
                 else if (timer_done) m_state = M_DONE;
        M_PAUSE: if (sp) m_state = M_IDLE;
                 else if (can_start) m_state = M_COOK;
        default: if (sp || !ok) m_state = M_IDLE;
                 else if (can_start) m_state = M_COOK;
      endcase
      for (int i = S; i > 0; i--) begin
        st_h[i] = st_h[i-1];
        sp_h[i] = sp_h[i-1];
        dr_h[i] = dr_h[i-1];
      end
      st_h[0] = startn;
      sp_h[0] = stopn;
      dr_h[0] = door_closed;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".state"},    32'(state),    32'(m_state));
    check({tag, ".mag_on"},   32'(mag_on),   32'(m_state == M_COOK));
    check({tag, ".timer_en"}, 32'(timer_en), 32'(m_state == M_COOK));
    check({tag, ".done"},     32'(done),     32'(m_state == M_DONE));
  endtask

  // Advance n edges, comparing against the model after each one.
  task automatic tick(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_model(tag);
    end
  endtask

  initial begin
    clrn = 1'b0; startn = 1'b1; stopn = 1'b1; door_closed = 1'b0; timer_done = 1'b0;
    #1;
    check("reset.state", 32'(state), 32'd0);
    check("reset.outs", 32'({mag_on, timer_en, done}), 32'd0);
    @(negedge clk);
    tick(2, "in_reset");
    clrn = 1'b1;
    door_closed = 1'b1;
    tick(3, "door_close");

    // Start with door closed: COOK exactly after edge S.
    startn = 1'b0;
    tick(1, "start_e0");
    check("start_e0", 32'(state), 32'd0);
    tick(1, "start_e1");
    check("start_e1", 32'(state), 32'd0);
    tick(1, "start_e2");
    check("start_cook", 32'({state, mag_on, timer_en}), 32'b0111);
    tick(5, "start_hold");
    check("hold_cook", 32'(state), 32'd1);

    // Stop then restart; holding start gives a single press.
    startn = 1'b1; stopn = 1'b0;
    tick(3, "stop");
    check("stop_pause", 32'({state, mag_on}), 32'b100);
    stopn = 1'b1;
    tick(3, "stop_rel");
    startn = 1'b0;
    tick(3, "resume");
    check("resume_cook", 32'({state, mag_on}), 32'b011);
    tick(4, "resume_hold");
    startn = 1'b1;
    tick(2, "resume_rel");

    // Door opens mid-cook; a start with the door open is not queued.
    door_closed = 1'b0;
    tick(3, "door_open");
    check("door_pause", 32'({state, mag_on}), 32'b100);
    startn = 1'b0;
    tick(3, "start_door_open");
    startn = 1'b1;
    door_closed = 1'b1;
    tick(4, "door_reclose");
    check("no_queue", 32'(state), 32'd2);
    startn = 1'b0;
    tick(3, "door_resume");
    check("door_resume", 32'(state), 32'd1);
    startn = 1'b1;
    tick(2, "door_rel");

    // Timer expiry acts on the next edge; start blocked while timer_done=1.
    timer_done = 1'b1;
    tick(1, "timer");
    check("timer_done", 32'({state, done, mag_on}), 32'b1110);
    startn = 1'b0;
    tick(3, "start_timer_hi");
    check("timer_block", 32'(state), 32'd3);
    timer_done = 1'b0;
    startn = 1'b1;
    tick(2, "timer_rel");
    stopn = 1'b0;
    tick(3, "done_stop");
    check("done_idle", 32'(state), 32'd0);
    stopn = 1'b1;
    tick(2, "done_stop_rel");

    // Simultaneous start and stop from PAUSE: stop wins.
    startn = 1'b0;
    tick(3, "to_cook");
    startn = 1'b1; stopn = 1'b0;
    tick(3, "to_pause");
    stopn = 1'b1;
    tick(3, "pause_rel");
    check("pre_conflict", 32'(state), 32'd2);
    startn = 1'b0; stopn = 1'b0;
    tick(3, "conflict");
    check("conflict_idle", 32'(state), 32'd0);
    startn = 1'b1; stopn = 1'b1;
    tick(2, "conflict_rel");

    // Asynchronous reset mid-cook drops mag_on without a clock edge.
    startn = 1'b0;
    tick(3, "pre_reset_cook");
    check("pre_reset_cook", 32'(mag_on), 32'd1);
    startn = 1'b1;
    @(posedge clk);
    #2 clrn = 1'b0;
    #1;
    check("async_rst.mag_on", 32'(mag_on), 32'd0);
    check("async_rst.state", 32'(state), 32'd0);
    @(negedge clk);
    check_model("async_rst");
    clrn = 1'b1;
    tick(2, "post_reset");

    // Random activity against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) startn = ~startn;
      if ($urandom_range(0, 6) == 0) stopn = ~stopn;
      if ($urandom_range(0, 9) == 0) door_closed = ~door_closed;
      timer_done = ($urandom_range(0, 11) == 0);
      tick(1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/microwave_control.md
Name:
microwave_control

Overview:
- Magnetron control FSM for the microwave oven; sits between the front-panel buttons/door switch and the cook timer.
- Turns the magnetron on when START is pressed with the door closed.
- Turns it off on STOP, door opening, timer expiry or clear.
- Enables the timer only while cooking and reports oven state.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each synchronizer for startn, stopn and door_closed; legal range ≥2.

Ports:
clk  input  1  system clock; all state changes on rising edge
clrn  input  1  asynchronous active-low reset/clear
startn  input  1  START pushbutton, active-low, asynchronous
stopn  input  1  STOP pushbutton, active-low, asynchronous
door_closed  input  1  door switch, 1 = closed, asynchronous
timer_done  input  1  cook timer expired, level, synchronous to clk
mag_on  output  1  magnetron enable
timer_en  output  1  timer count enable
done  output  1  cook cycle finished
state  output  2  current state: 00 IDLE, 01 COOK, 10 PAUSE, 11 DONE

Behaviour:
Reset:
- Interface: one clock (clk); reset is asynchronous and active-low (clrn).
- clrn=0 immediately forces state=IDLE and mag_on=timer_en=done=0.
- Synchronizer flops reset to their inactive levels: startn/stopn chains to 1, door_closed chain to 0.
- Reset mid-cook drops mag_on with no clock required.

Input conditioning:
- startn, stopn and door_closed each pass through a SYNC_STAGES-flop synchronizer.
- start_press = one-cycle pulse when synchronized startn goes 1→0. stop_press is defined the same way for stopn.
- Holding a button produces exactly one press.
- door_ok = synchronized door_closed.
- timer_done is used unsynchronized.

FSM, registered state, evaluated each rising edge; within each state, transition conditions are listed highest priority first:
- IDLE:
  - start_press & door_ok & !timer_done → COOK
  - otherwise stay
- COOK:
  - !door_ok → PAUSE (safety, highest priority)
  - timer_done → DONE
  - stop_press → PAUSE
  - otherwise stay
- PAUSE:
  - stop_press → IDLE (cancel)
  - start_press & door_ok & !timer_done → COOK (resume)
  - otherwise stay
- DONE:
  - stop_press or !door_ok → IDLE
  - start_press & door_ok & !timer_done → COOK
  - otherwise stay
- Simultaneous start_press and stop_press: stop wins; start is ignored.

Outputs (decoded directly from the state register, glitch-free):
- mag_on = timer_en = (state==COOK)
- done = (state==DONE)
- state presents the state register.

Latency:
- Edge 0 is the first rising edge that samples a new level on startn, stopn or door_closed.
- The state change is visible after edge SYNC_STAGES. Default: 2 edges after the input change.
- timer_done acts at the next rising edge.

Other rules:
- mag_on is never 1 while door_ok=0 for more than one cycle.
- With door_ok=0, a start press is ignored; it is not queued.

Test Plan:
- Start with door closed: clrn released, door_closed=1, startn pulsed 1→0 → mag_on=1, timer_en=1, state=01 two clocks after the sampled edge.
- Stop then restart: while cooking, stopn=0 (startn=1) → state=10, mag_on=0. Release stopn, press startn → state=01, mag_on=1. Holding startn low gives no further transitions.
- Door opens mid-cook: door_closed=0 → mag_on=0, state=10 within SYNC_STAGES clocks. startn press with door open → stays 10. Close door and press start → 01.
- Timer expiry: in COOK, timer_done=1 for one clock → state=11, done=1, mag_on=0. Start press while timer_done=1 → no change. stopn press → state=00.
- Conflicts and reset: startn and stopn falling in the same cycle from PAUSE → state=00. clrn=0 asynchronously mid-COOK → mag_on=0 before the next clk edge, state=00.
